scan_chain_ctrl: RTL and testbench

//   Master end of the muxed-D scan interface used by the PC register and the other scanned blocks.

---
 rtl/scan_chain_ctrl.sv | 82 ++++++++
 tb/tb_scan_chain_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain master: shifts a parallel word into a muxed-D scan chain for CHAIN_LEN
// cycles while capturing the chain's serial output into o_rdata.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 17,
    parameter int CNT_WIDTH = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [CHAIN_LEN-1:0] i_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_rdata,
    output logic                 o_scan_en,
    output logic                 o_scan_in,
    input  logic                 i_scan_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CHAIN_LEN - 1);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] count;
    logic [CHAIN_LEN-1:0] shift_reg;
    logic [CHAIN_LEN-2:0] capture;
    logic [CHAIN_LEN-1:0] capture_next;
    logic [CHAIN_LEN-1:0] rdata;
    logic                 mode;

    // capture only keeps the bits still needed; the oldest bit leaves via capture_next
    assign capture_next = {capture, i_scan_out};

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            capture   <= '0;
            rdata     <= '0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        mode      <= i_mode;
                        shift_reg <= i_wdata;
                        count     <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    capture   <= capture_next[CHAIN_LEN-2:0];
                    shift_reg <= {shift_reg[CHAIN_LEN-2:0], 1'b0};
                    if (count == LAST) begin
                        rdata <= capture_next;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All strobes decode from registered state so scan_en never glitches on i_start
    assign o_scan_en = (state == SHIFT);
    assign o_done    = (state == DONE);
    assign o_busy    = (state == SHIFT) || (state == DONE);
    assign o_rdata   = rdata;
    assign o_scan_in = o_scan_en & (mode ? i_scan_out : shift_reg[CHAIN_LEN-1]);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving a 17-flop PC scan chain model (tail flop + PC[15:0]).
module tb_scan_chain_ctrl;

    localparam int N = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic [N-1:0] rdata;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;

    // chain: scan_in -> PC[0] .. PC[15] -> tail -> scan_out ; chain[16] is the tail
    logic [N-1:0] chain;
    logic         stall;
    logic         load;
    logic [N-1:0] load_val;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .i_start   (start),
        .i_mode    (mode),
        .i_wdata   (wdata),
        .o_busy    (busy),
        .o_done    (done),
        .o_rdata   (rdata),
        .o_scan_en (scan_en),
        .o_scan_in (scan_in),
        .i_scan_out(scan_out)
    );

    always @(posedge clk) begin
        if (scan_en)
            chain <= {chain[N-2:0], scan_in};
        else if (load && !stall)
            chain <= load_val;
    end
    assign scan_out = chain[N-1];

    typedef struct {
        logic         mode;
        logic [N-1:0] wdata;
        logic [N-1:0] init;
        logic         stall;
        logic [N-1:0] exp_rdata;
        logic [N-1:0] exp_chain;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a completed op reads the old chain; exchange leaves wdata, recirculate leaves old
    function automatic logic [N-1:0] after_op(input logic m, input logic [N-1:0] init,
                                               input logic [N-1:0] w);
        return m ? init : w;
    endfunction

    // After k exchange shifts the chain is a k-bit-advanced window over {old, new}
    function automatic logic [N-1:0] partial(input logic [N-1:0] init, input logic [N-1:0] w,
                                             input int k);
        logic [2*N-1:0] cat;
        cat = {init, w} << k;
        return cat[2*N-1:N];
    endfunction

    task automatic preset(input logic [N-1:0] v);
        @(negedge clk);
        stall    = 1'b0;
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic [N-1:0] w, input int pulse_a,
                          input int pulse_b, input int rst_at, input logic scramble,
                          output logic [N-1:0] got, output int en_cycles,
                          output int done_at, output int done_cnt, output int bad_busy);
        got = '0; en_cycles = 0; done_at = -1; done_cnt = 0; bad_busy = 0;
        @(negedge clk);
        mode  = m;
        wdata = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            if (n > 1) @(negedge clk);
            if (scan_en) en_cycles++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
                got = rdata;
            end
            if (rst_at == 0 && busy !== (n <= N + 1)) bad_busy++;
            if (scramble) begin
                mode  = 1'($urandom);
                wdata = N'($urandom);
            end
            start = (n == pulse_a) || (n == pulse_b);
            if (n == rst_at) begin
                #2 rst = 1'b1;
                #1 check("rst_async_ctl", {28'd0, scan_en, scan_in, busy, done}, 32'd0);
                check("rst_async_rdata", 32'(rdata), 32'd0);
                #1 rst = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [N-1:0] got, part, w, c;
        int en_c, d_at, d_cnt, bb;
        int dt[$];

        rst = 1'b1; start = 1'b0; mode = 1'b0; wdata = '0;
        stall = 1'b0; load = 1'b0; load_val = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {14'd0, scan_en, scan_in, busy, done, 14'd0}, 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_release", {31'd0, busy}, 32'd0);

        vecs[0] = '{1'b0, 17'h0ABCD, 17'h01234, 1'b0, 17'h01234, 17'h0ABCD};
        vecs[1] = '{1'b1, 17'h00000, 17'h1BEEF, 1'b0, 17'h1BEEF, 17'h1BEEF};
        vecs[2] = '{1'b0, 17'h0ABCD, 17'h01234, 1'b1, 17'h01234, 17'h0ABCD};
        for (int i = 3; i < 12; i++) begin
            vecs[i].mode      = 1'($urandom);
            vecs[i].wdata     = N'($urandom);
            vecs[i].init      = N'($urandom);
            vecs[i].stall     = 1'($urandom);
            vecs[i].exp_rdata = vecs[i].init;
            vecs[i].exp_chain = after_op(vecs[i].mode, vecs[i].init, vecs[i].wdata);
        end

        for (int i = 0; i < 12; i++) begin
            preset(vecs[i].init);
            stall = vecs[i].stall;
            run_op(vecs[i].mode, vecs[i].wdata, 0, 0, 0, 1'b1, got, en_c, d_at, d_cnt, bb);
            check($sformatf("v%0d_rdata", i), 32'(got), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d_chain", i), 32'(chain), 32'(vecs[i].exp_chain));
            check($sformatf("v%0d_scan_en_cycles", i), en_c, 17);
            check($sformatf("v%0d_done_cycle", i), d_at, 18);
            check($sformatf("v%0d_done_count", i), d_cnt, 1);
            check($sformatf("v%0d_busy", i), bb, 0);
            check($sformatf("v%0d_rdata_hold", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            stall = 1'b0;
        end

        // start pulses while busy (SHIFT k=5 and DONE) must be ignored
        preset(17'h05555);
        run_op(1'b0, 17'h1F0F0, 6, 18, 0, 1'b0, got, en_c, d_at, d_cnt, bb);
        check("busy_start_rdata", 32'(got), 32'h05555);
        check("busy_start_en_cycles", en_c, 17);
        check("busy_start_done_count", d_cnt, 1);
        check("busy_start_chain", 32'(chain), 32'h1F0F0);

        // reset after 8 shifts, then a fresh exchange reads the half-shifted chain
        c = 17'h1A5A5; w = 17'h0C3F1;
        preset(c);
        run_op(1'b0, w, 0, 0, 9, 1'b0, got, en_c, d_at, d_cnt, bb);
        part = partial(c, w, 8);
        check("midrst_done_count", d_cnt, 0);
        check("midrst_en_cycles", en_c, 9);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_chain", 32'(chain), 32'(part));
        run_op(1'b0, 17'h12468, 0, 0, 0, 1'b0, got, en_c, d_at, d_cnt, bb);
        check("post_rst_rdata", 32'(got), 32'(part));
        check("post_rst_chain", 32'(chain), 32'h12468);
        check("post_rst_done_cycle", d_at, 18);

        // i_start held high: back-to-back ops spaced CHAIN_LEN+2 cycles
        preset(17'h01234);
        stall = 1'b1;
        @(negedge clk);
        mode = 1'b0; wdata = 17'h0ABCD; start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin
                dt.push_back(n);
                if (dt.size() == 1) check("b2b_rdata0", 32'(rdata), 32'h01234);
                if (dt.size() == 2) check("b2b_rdata1", 32'(rdata), 32'h0ABCD);
            end
            if (n == 55) start = 1'b0;
        end
        stall = 1'b0;
        check("b2b_done_count", dt.size(), 3);
        if (dt.size() == 3) begin
            check("b2b_first", dt[0], 18);
            check("b2b_spacing1", dt[1] - dt[0], 19);
            check("b2b_spacing2", dt[2] - dt[1], 19);
        end
        check("b2b_chain", 32'(chain), 32'h0ABCD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
